// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared types and helpers for the multi-channel seconds timer.
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_t;

    // Sub-second counter width; CLK_HZ is at least 2, so $clog2 is never 0.
    function automatic int sub_width(input int clk_hz);
        return (clk_hz > 2) ? $clog2(clk_hz) : 1;
    endfunction

    // Read-select width; a single channel still gets a 1-bit select.
    function automatic int sel_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    // LSB position of channel ch inside a packed per-channel bus.
    function automatic int ch_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_sec_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : multi_sec_timer_if
//  Description : Control/status bundle between the control FSM and the timer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface multi_sec_timer_if #(
    parameter int CNT_W = 16,
    parameter int N_CH  = 4
);
    import timer_pkg::*;

    localparam int SEL_W = sel_width(N_CH);

    logic [N_CH-1:0]       start;
    logic [N_CH-1:0]       stop;
    logic [N_CH-1:0]       periodic;
    logic [N_CH*CNT_W-1:0] duration;
    logic [SEL_W-1:0]      rd_sel;
    logic [N_CH-1:0]       busy;
    logic [N_CH-1:0]       done;
    logic [CNT_W-1:0]      remaining;

    modport master (
        output start, stop, periodic, duration, rd_sel,
        input  busy, done, remaining
    );

    modport slave (
        input  start, stop, periodic, duration, rd_sel,
        output busy, done, remaining
    );

endinterface
`default_nettype wire

// File: rtl/timer_channel.sv
`default_nettype none
// ============================================================================
//  Module      : timer_channel
//  Description : One programmable seconds channel: IDLE/RUN FSM, sub-second and
//                seconds counters, one-shot or auto-reload expiry pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_channel
    import timer_pkg::*;
#(
    parameter int CLK_HZ = 10000,
    parameter int CNT_W  = 16
) (
    input  wire logic             CLK,
    input  wire logic             reset,
    input  wire logic             start,
    input  wire logic             stop,
    input  wire logic             periodic,
    input  wire logic [CNT_W-1:0] duration,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      sec
);

    localparam int               SUB_W      = sub_width(CLK_HZ);
    localparam logic [SUB_W-1:0] c_sub_last = SUB_W'(CLK_HZ - 1);
    localparam logic [CNT_W-1:0] c_sec_one  = CNT_W'(1);

    ch_state_t        r_state, w_state_nxt;
    logic [SUB_W-1:0] r_sub,   w_sub_nxt;
    logic [CNT_W-1:0] r_sec,   w_sec_nxt;
    logic [CNT_W-1:0] r_dur,   w_dur_nxt;
    logic             r_per,   w_per_nxt;
    logic             r_done,  w_done_nxt;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_sub   <= '0;
            r_sec   <= '0;
            r_dur   <= '0;
            r_per   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sub   <= w_sub_nxt;
            r_sec   <= w_sec_nxt;
            r_dur   <= w_dur_nxt;
            r_per   <= w_per_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Priority: stop, then start/retrigger, then the running count.
    always_comb begin
        w_state_nxt = r_state;
        w_sub_nxt   = r_sub;
        w_sec_nxt   = r_sec;
        w_dur_nxt   = r_dur;
        w_per_nxt   = r_per;
        w_done_nxt  = 1'b0;

        if (stop) begin
            w_state_nxt = ST_IDLE;
            w_sub_nxt   = '0;
            w_sec_nxt   = '0;
        end else if (start) begin
            w_dur_nxt = duration;
            w_per_nxt = periodic;
            w_sub_nxt = '0;
            if (duration == '0) begin
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
                w_sec_nxt   = '0;
            end else begin
                w_state_nxt = ST_RUN;
                w_sec_nxt   = duration;
            end
        end else if (r_state == ST_RUN) begin
            if (r_sub == c_sub_last) begin
                w_sub_nxt = '0;
                if (r_sec == c_sec_one) begin
                    w_done_nxt = 1'b1;
                    if (r_per) begin
                        w_sec_nxt = r_dur;
                    end else begin
                        w_sec_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_sec_nxt = r_sec - c_sec_one;
                end
            end else begin
                w_sub_nxt = r_sub + SUB_W'(1);
            end
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = r_done;
    assign sec  = r_sec;

endmodule
`default_nettype wire

// File: rtl/multi_sec_timer.sv
`default_nettype none
// ============================================================================
//  Module      : multi_sec_timer
//  Description : N independent seconds-timer channels with a registered
//                remaining-time readback mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_sec_timer
    import timer_pkg::*;
#(
    parameter int CLK_HZ = 10000,
    parameter int CNT_W  = 16,
    parameter int N_CH   = 4
) (
    input  wire logic        CLK,
    input  wire logic        reset,
    multi_sec_timer_if.slave bus
);

    localparam int SEL_W  = sel_width(N_CH);
    localparam int N_SLOT = 1 << SEL_W;

    // Slots beyond N_CH read as zero so every rd_sel code is defined.
    logic [CNT_W-1:0] w_sec [N_SLOT];
    logic [CNT_W-1:0] r_remaining;

    genvar gi;
    for (gi = 0; gi < N_SLOT; gi++) begin : g_ch
        if (gi < N_CH) begin : g_live
            timer_channel #(
                .CLK_HZ (CLK_HZ),
                .CNT_W  (CNT_W)
            ) u_channel (
                .CLK      (CLK),
                .reset    (reset),
                .start    (bus.start[gi]),
                .stop     (bus.stop[gi]),
                .periodic (bus.periodic[gi]),
                .duration (bus.duration[ch_lsb(gi, CNT_W) +: CNT_W]),
                .busy     (bus.busy[gi]),
                .done     (bus.done[gi]),
                .sec      (w_sec[gi])
            );
        end else begin : g_pad
            assign w_sec[gi] = '0;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_remaining <= '0;
        end else begin
            r_remaining <= w_sec[bus.rd_sel];
        end
    end

    assign bus.remaining = r_remaining;

endmodule
`default_nettype wire

// File: tb/tb_multi_sec_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_sec_timer
//  Description : Scoreboard bench for multi_sec_timer against an expiry-time model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_sec_timer;

    localparam int CLK_HZ = 10;
    localparam int CNT_W  = 8;
    localparam int N_CH   = 4;

    logic CLK   = 1'b0;
    logic reset = 1'b0;
    always #5 CLK = ~CLK;

    multi_sec_timer_if #(.CNT_W(CNT_W), .N_CH(N_CH)) bus ();

    multi_sec_timer #(
        .CLK_HZ (CLK_HZ),
        .CNT_W  (CNT_W),
        .N_CH   (N_CH)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [N_CH-1:0]  busy;
        logic [N_CH-1:0]  done;
        logic [CNT_W-1:0] rem;
    } exp_t;

    exp_t q[$];
    exp_t mon_x;

    int errors = 0;
    int checks = 0;
    int ecnt   = 0;

    // Pending stimulus for the next sampling edge.
    logic [N_CH-1:0]  st_v  = '0;
    logic [N_CH-1:0]  sp_v  = '0;
    logic [N_CH-1:0]  per_v = '0;
    logic [CNT_W-1:0] dur_v [N_CH];
    logic [1:0]       sel_v = '0;
    logic             rst_v = 1'b0;

    // Model: the absolute edge at which each channel next expires (-1 = idle).
    longint m_nxt [N_CH];
    int     m_dur [N_CH];
    bit     m_per [N_CH];

    always @(posedge CLK) ecnt <= ecnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, ecnt, act, exp);
        end
    endtask

    // Whole seconds left after edge p: remaining cycles rounded up.
    function automatic int sec_left(input int ch, input longint p);
        if (m_nxt[ch] < 0) return 0;
        return int'((m_nxt[ch] - p + CLK_HZ - 1) / CLK_HZ);
    endfunction

    task automatic step();
        exp_t   x;
        longint e;
        @(negedge CLK);
        reset        = rst_v;
        bus.start    = st_v;
        bus.stop     = sp_v;
        bus.periodic = per_v;
        for (int c = 0; c < N_CH; c++) bus.duration[c*CNT_W +: CNT_W] = dur_v[c];
        bus.rd_sel   = sel_v;

        e      = longint'(ecnt) + 1;
        x.rem  = rst_v ? CNT_W'(sec_left(int'(sel_v), e - 1)) : '0;
        x.done = '0;
        x.busy = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (!rst_v) begin
                m_nxt[c] = -1; m_dur[c] = 0; m_per[c] = 1'b0;
            end else if (sp_v[c]) begin
                m_nxt[c] = -1;
            end else if (st_v[c]) begin
                m_dur[c] = int'(dur_v[c]);
                m_per[c] = per_v[c];
                if (m_dur[c] == 0) begin
                    x.done[c] = 1'b1;
                    m_nxt[c]  = -1;
                end else begin
                    m_nxt[c] = e + longint'(m_dur[c]) * CLK_HZ;
                end
            end else if (m_nxt[c] == e) begin
                x.done[c] = 1'b1;
                m_nxt[c]  = m_per[c] ? e + longint'(m_dur[c]) * CLK_HZ : -1;
            end
            x.busy[c] = (m_nxt[c] >= 0);
        end
        q.push_back(x);

        if (!rst_v) begin
            #1;
            chk("reset_busy", 32'(bus.busy), 32'(0));
            chk("reset_done", 32'(bus.done), 32'(0));
            chk("reset_remaining", 32'(bus.remaining), 32'(0));
        end
        st_v = '0;
        sp_v = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    always @(posedge CLK) begin
        #1;
        if (q.size() > 0) begin
            mon_x = q.pop_front();
            chk("done", 32'(bus.done), 32'(mon_x.done));
            chk("busy", 32'(bus.busy), 32'(mon_x.busy));
            chk("remaining", 32'(bus.remaining), 32'(mon_x.rem));
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        for (int c = 0; c < N_CH; c++) begin
            dur_v[c] = '0; m_nxt[c] = -1; m_dur[c] = 0; m_per[c] = 1'b0;
        end

        // Reset mid-run aborts silently.
        rst_v = 1'b0; idle(3);
        rst_v = 1'b1; idle(2);
        dur_v[0] = 8'd3; st_v = 4'b0001; step();
        idle(12);
        rst_v = 1'b0; step(); step();
        rst_v = 1'b1; idle(35);

        // One-shot ch0, remaining 3,2,1,0.
        sel_v = 2'd0; dur_v[0] = 8'd3; per_v = '0; st_v = 4'b0001; step();
        idle(35);

        // Periodic ch1, stopped at T+45.
        sel_v = 2'd1; dur_v[1] = 8'd2; per_v = 4'b0010; st_v = 4'b0010; step();
        idle(44);
        sp_v = 4'b0010; step();
        idle(25);
        per_v = '0;

        // Zero duration, then start+stop together.
        sel_v = 2'd2; dur_v[2] = 8'd0; st_v = 4'b0100; step();
        idle(3);
        sel_v = 2'd3; dur_v[3] = 8'd5; st_v = 4'b1000; sp_v = 4'b1000; step();
        idle(5);

        // Retrigger ch0 with a shorter duration.
        sel_v = 2'd0; dur_v[0] = 8'd5; st_v = 4'b0001; step();
        idle(24);
        dur_v[0] = 8'd2; st_v = 4'b0001; step();
        idle(30);

        // All channels expire together.
        for (int c = 0; c < N_CH; c++) dur_v[c] = 8'd1;
        st_v = 4'b1111; step();
        idle(15);

        // Randomized traffic, including duration changes while running.
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < N_CH; c++) begin
                st_v[c]  = ($urandom_range(0, 39) == 0);
                sp_v[c]  = ($urandom_range(0, 99) == 0);
                per_v[c] = 1'($urandom_range(0, 1));
                dur_v[c] = CNT_W'($urandom_range(0, 3));
            end
            sel_v = 2'($urandom_range(0, 3));
            rst_v = !(i >= 700 && i < 702);
            step();
        end
        rst_v = 1'b1;
        st_v  = '0;
        sp_v  = '0;
        idle(45);
        repeat (2) @(posedge CLK);
        #2;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
